// File: rtl/axis_uart_rx_os.sv
// Oversampling UART receiver with AXI-Stream output and per-word error flags.
// Majority-voted bit sampling, false-start rejection, single-entry output register.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | line idle, waiting for a falling edge on rx_s
// ST_START   | start bit; a voted 1 is a false start
// ST_DATA    | data bits, LSB first
// ST_PARITY  | parity bit (only when parity is enabled)
// ST_STOP    | one or two stop bits; leaves at mid-point of the last one
// ST_DELIVER | one cycle: hand the word to the output register
module axis_uart_rx_os #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DIV_W-1:0]  clk_divider_i,
  input  logic [3:0]        data_bits_i,
  input  logic [1:0]        parity_i,
  input  logic              stop_bits_i,
  input  logic              uart_rx_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [3:0]        m_axis_tuser,
  output logic              busy_o
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_RES = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DELIVER
  } state_t;

  state_t state_r, state_nx;

  logic              rx_q1, rx_s, rx_d;
  logic [DIV_W-1:0]  div_r, cnt_r;
  logic [3:0]        nbits_r, nbits_in, bit_cnt_r;
  logic              par_en_r, par_odd_r, stop2_r, stop_idx_r;
  logic [SW-1:0]     s_r;
  logic              v0_r, v1_r;
  logic [DATA_W-1:0] data_r;
  logic              pe_r, fe_r, zero_r, ovr_r;
  logic              start_edge, tick, sample_mid, bit_end, vote, par_exp;

  assign start_edge = rx_d & ~rx_s;
  assign tick       = (state_r != ST_IDLE) && (cnt_r == div_r - DIV_W'(1));
  assign sample_mid = tick && (s_r == S_RES);
  assign bit_end    = tick && (s_r == S_END);
  assign vote       = (v0_r & v1_r) | (v0_r & rx_s) | (v1_r & rx_s);
  assign par_exp    = par_odd_r ? ~(^data_r) : ^data_r;
  assign busy_o     = (state_r != ST_IDLE);

  always_comb begin
    nbits_in = data_bits_i;
    if (data_bits_i < 4'd5)
      nbits_in = 4'd5;
    else if (data_bits_i > 4'(DATA_W))
      nbits_in = 4'(DATA_W);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_r <= ST_IDLE;
    else          state_r <= state_nx;
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:    if (start_edge) state_nx = ST_START;
      ST_START: begin
        if (sample_mid && vote) state_nx = ST_IDLE;
        else if (bit_end)       state_nx = ST_DATA;
      end
      ST_DATA:
        if (bit_end && (bit_cnt_r == nbits_r - 4'd1))
          state_nx = par_en_r ? ST_PARITY : ST_STOP;
      ST_PARITY:  if (bit_end) state_nx = ST_STOP;
      // Leave at mid-point of the last stop bit so a following start edge is seen.
      ST_STOP:    if (sample_mid && (!stop2_r || stop_idx_r)) state_nx = ST_DELIVER;
      ST_DELIVER: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rx_q1      <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      div_r      <= DIV_W'(1);
      cnt_r      <= '0;
      nbits_r    <= 4'(DATA_W);
      bit_cnt_r  <= '0;
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      stop2_r    <= 1'b0;
      stop_idx_r <= 1'b0;
      s_r        <= '0;
      v0_r       <= 1'b1;
      v1_r       <= 1'b1;
      data_r     <= '0;
      pe_r       <= 1'b0;
      fe_r       <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      rx_q1 <= uart_rx_i;
      rx_s  <= rx_q1;
      rx_d  <= rx_s;
      if (state_r == ST_IDLE) begin
        cnt_r      <= '0;
        s_r        <= '0;
        bit_cnt_r  <= '0;
        stop_idx_r <= 1'b0;
        if (start_edge) begin
          div_r     <= (clk_divider_i == '0) ? DIV_W'(1) : clk_divider_i;
          nbits_r   <= nbits_in;
          par_en_r  <= (parity_i == 2'd1) || (parity_i == 2'd2);
          par_odd_r <= (parity_i == 2'd1);
          stop2_r   <= stop_bits_i;
          data_r    <= '0;
          pe_r      <= 1'b0;
          fe_r      <= 1'b0;
          zero_r    <= 1'b1;
        end
      end else begin
        cnt_r <= tick ? '0 : cnt_r + DIV_W'(1);
        if (tick) begin
          s_r <= (s_r == S_END) ? '0 : s_r + SW'(1);
          if (s_r == S_V0) v0_r <= rx_s;
          if (s_r == S_V1) v1_r <= rx_s;
        end
        if (sample_mid) begin
          case (state_r)
            ST_DATA: begin
              for (int i = 0; i < DATA_W; i++)
                if (bit_cnt_r == 4'(i)) data_r[i] <= vote;
              if (vote) zero_r <= 1'b0;
            end
            ST_PARITY: begin
              pe_r <= (vote != par_exp);
              if (vote) zero_r <= 1'b0;
            end
            ST_STOP: begin
              if (!vote) fe_r <= 1'b1;
              if (vote && !stop_idx_r) zero_r <= 1'b0;
            end
            default: ;
          endcase
        end
        if (bit_end) begin
          if (state_r == ST_DATA) bit_cnt_r <= bit_cnt_r + 4'd1;
          if (state_r == ST_STOP) stop_idx_r <= 1'b1;
        end
      end
    end
  end

  // A new word can load in the same cycle the held one is accepted.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      ovr_r         <= 1'b0;
    end else if (state_r == ST_DELIVER) begin
      if (m_axis_tvalid && !m_axis_tready) begin
        ovr_r <= 1'b1;
      end else begin
        m_axis_tdata  <= data_r;
        m_axis_tuser  <= {ovr_r, zero_r, fe_r, pe_r};
        m_axis_tvalid <= 1'b1;
        ovr_r         <= 1'b0;
      end
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_uart_rx_os.sv
// Directed bench for axis_uart_rx_os: frames are bit-banged on uart_rx_i and
// the accepted stream beats are compared with hand-computed words and flags.
module tb_axis_uart_rx_os;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic [15:0] clk_divider_i = 16'd2;
  logic [3:0]  data_bits_i = 4'd8;
  logic [1:0]  parity_i = 2'd0;
  logic        stop_bits_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [3:0]  m_axis_tuser;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_data[$];
  logic [3:0] q_user[$];

  axis_uart_rx_os #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .clk_divider_i (clk_divider_i),
    .data_bits_i   (data_bits_i),
    .parity_i      (parity_i),
    .stop_bits_i   (stop_bits_i),
    .uart_rx_i     (uart_rx_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // tready only changes just after a rising edge, so a beat seen here is the one taken next edge.
  always @(negedge clk_i) begin
    if (arstn_i && m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_user.push_back(m_axis_tuser);
    end
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drive_bit(input logic b, input int bitc);
    uart_rx_i = b;
    repeat (bitc) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input int par, input int nstop,
                            input bit flip_par, input bit stop0, input int bitc);
    logic p;
    p = 1'b0;
    drive_bit(1'b0, bitc);
    for (int i = 0; i < nb; i++) begin
      drive_bit(d[i], bitc);
      p = p ^ d[i];
    end
    if (par == 1) p = ~p;
    if (flip_par) p = ~p;
    if (par == 1 || par == 2) drive_bit(p, bitc);
    for (int k = 0; k < nstop; k++) drive_bit((k == 0 && stop0) ? 1'b0 : 1'b1, bitc);
    uart_rx_i = 1'b1;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] exp_d, input logic [3:0] exp_u);
    int k;
    k = 0;
    while (q_data.size() == 0 && k < 3000) begin
      @(negedge clk_i);
      k++;
    end
    if (q_data.size() == 0) begin
      check_val({tag, "_timeout"}, 16'd0, 16'd1);
    end else begin
      check_val({tag, "_tdata"}, 16'(q_data.pop_front()), 16'(exp_d));
      check_val({tag, "_tuser"}, 16'(q_user.pop_front()), 16'(exp_u));
    end
  endtask

  typedef struct { logic [7:0] d; int bitc; } tol_vec_t;
  tol_vec_t tol_tab[6] = '{
    '{8'h00, 124}, '{8'hFF, 124}, '{8'h5A, 124},
    '{8'h00, 132}, '{8'hFF, 132}, '{8'h5A, 132}
  };

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(5);
    check_val("rst_tvalid", 16'(m_axis_tvalid), 16'd0);
    check_val("rst_tdata",  16'(m_axis_tdata),  16'd0);
    check_val("rst_tuser",  16'(m_axis_tuser),  16'd0);
    check_val("rst_busy",   16'(busy_o),        16'd0);
    arstn_i = 1'b1;
    idle(10);

    // Basic 8N1 frame, divider 2 -> 32 clocks per bit
    send_frame(9'h0A5, 8, 0, 1, 1'b0, 1'b0, 32);
    expect_beat("basic", 8'hA5, 4'b0000);
    idle(64);
    check_val("basic_single_beat", 16'(q_data.size()), 16'd0);

    // Even parity, 7 data bits, 2 stop bits
    data_bits_i = 4'd7; parity_i = 2'd2; stop_bits_i = 1'b1;
    send_frame(9'h055, 7, 2, 2, 1'b0, 1'b0, 32);
    expect_beat("par_ok", 8'h55, 4'b0000);
    idle(64);
    send_frame(9'h055, 7, 2, 2, 1'b1, 1'b0, 32);
    expect_beat("par_bad", 8'h55, 4'b0001);
    idle(64);

    // Framing error, then a break
    data_bits_i = 4'd8; parity_i = 2'd0; stop_bits_i = 1'b0;
    send_frame(9'h03C, 8, 0, 1, 1'b0, 1'b1, 32);
    expect_beat("framing", 8'h3C, 4'b0010);
    idle(64);
    drive_bit(1'b0, 12 * 32);
    uart_rx_i = 1'b1;
    expect_beat("break", 8'h00, 4'b0110);
    idle(64);

    // Glitch rejection with divider 4
    clk_divider_i = 16'd4;
    uart_rx_i = 1'b0;
    idle(3);
    uart_rx_i = 1'b1;
    idle(3);
    check_val("glitch_busy_hi", 16'(busy_o), 16'd1);
    idle(64);
    check_val("glitch_busy_lo", 16'(busy_o), 16'd0);
    check_val("glitch_no_beat", 16'(q_data.size() + int'(m_axis_tvalid)), 16'd0);

    // Overrun with tready low
    clk_divider_i = 16'd2;
    @(posedge clk_i); #1 m_axis_tready = 1'b0;
    @(negedge clk_i);
    send_frame(9'h011, 8, 0, 1, 1'b0, 1'b0, 32);
    send_frame(9'h022, 8, 0, 1, 1'b0, 1'b0, 32);
    send_frame(9'h033, 8, 0, 1, 1'b0, 1'b0, 32);
    idle(64);
    check_val("ovr_hold_valid", 16'(m_axis_tvalid), 16'd1);
    check_val("ovr_hold_data",  16'(m_axis_tdata),  16'h11);
    @(posedge clk_i); #1 m_axis_tready = 1'b1;
    expect_beat("ovr_first", 8'h11, 4'b0000);
    @(negedge clk_i);
    send_frame(9'h044, 8, 0, 1, 1'b0, 1'b0, 32);
    expect_beat("ovr_next", 8'h44, 4'b1000);
    idle(64);
    check_val("ovr_no_extra", 16'(q_data.size()), 16'd0);

    // Reset in the middle of data bit 0
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 16);
    arstn_i = 1'b0;
    idle(4);
    check_val("midrst_tvalid", 16'(m_axis_tvalid), 16'd0);
    check_val("midrst_busy",   16'(busy_o),        16'd0);
    arstn_i = 1'b1;
    idle(400);
    check_val("midrst_no_beat", 16'(q_data.size()), 16'd0);
    send_frame(9'h081, 8, 0, 1, 1'b0, 1'b0, 32);
    expect_beat("post_rst", 8'h81, 4'b0000);
    idle(64);

    // Baud tolerance: divider 8 gives 128 clocks per bit nominally, driven at -3% and +3%
    clk_divider_i = 16'd8;
    foreach (tol_tab[i]) begin
      send_frame({1'b0, tol_tab[i].d}, 8, 0, 1, 1'b0, 1'b0, tol_tab[i].bitc);
      expect_beat($sformatf("tol_%0d", i), tol_tab[i].d, 4'b0000);
      idle(256);
    end
    check_val("tol_no_extra", 16'(q_data.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
